// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - two-port round-robin arbiter sharing one I2C master
// Optional watchdog abort: define I2C_ARB_TIMEOUT_EN.
module i2c_arbiter #(
  parameter logic [23:0] TMO_CYCLES = 24'd1_000_000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       a_start,
  input  logic       a_read,
  input  logic [6:0] a_addr,
  input  logic [7:0] a_subaddr,
  input  logic [7:0] a_dout,
  output logic [7:0] a_din,
  output logic       a_ack,
  output logic       a_end,
  input  logic       b_start,
  input  logic       b_read,
  input  logic [6:0] b_addr,
  input  logic [7:0] b_subaddr,
  input  logic [7:0] b_dout,
  output logic [7:0] b_din,
  output logic       b_ack,
  output logic       b_end,
  output logic       m_start,
  output logic       m_read,
  output logic [6:0] m_addr,
  output logic [7:0] m_subaddr,
  output logic [7:0] m_dout,
  input  logic [7:0] m_din,
  input  logic       m_ack,
  input  logic       m_end,
  output logic       timeout
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_BUSY} state_t;
  typedef enum logic [1:0] {GR_NONE, GR_A, GR_B} grant_t;

  state_t      state_q;
  grant_t      grant_q;
  logic        last_b_q;
  logic        a_pend_q;
  logic        b_pend_q;
  logic [23:0] a_req_q;
  logic [23:0] b_req_q;
  logic [7:0]  a_din_q;
  logic [7:0]  b_din_q;
  logic        a_ack_q;
  logic        b_ack_q;
  logic        m_start_q;
  logic [23:0] m_req_q;
  logic        timeout_q;

  logic        a_take_d;
  logic        b_take_d;
  logic        win_b_d;
  logic        done_d;
  logic        abort_d;
  logic [7:0]  cap_din_d;
  logic        cap_ack_d;

  // A start is dropped while its port already owns a pending or granted slot.
  assign a_take_d  = a_start & ~a_pend_q & (grant_q != GR_A);
  assign b_take_d  = b_start & ~b_pend_q & (grant_q != GR_B);
  assign win_b_d   = b_pend_q & (~a_pend_q | ~last_b_q);
  assign done_d    = (state_q == ST_BUSY) & m_end;

`ifdef I2C_ARB_TIMEOUT_EN
  logic [23:0] tmo_cnt_q;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= 24'd0;
    end else if (state_q == ST_IDLE) begin
      tmo_cnt_q <= 24'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 24'd1;
    end
  end

  assign abort_d = (state_q != ST_IDLE) & ~done_d & (tmo_cnt_q == TMO_CYCLES - 24'd1);
`else
  logic unused_tmo;
  assign unused_tmo = |TMO_CYCLES;
  assign abort_d    = 1'b0;
`endif

  assign cap_din_d = abort_d ? 8'hFF : m_din;
  assign cap_ack_d = ~abort_d & m_ack;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= GR_NONE;
      last_b_q  <= 1'b1;
      a_pend_q  <= 1'b0;
      b_pend_q  <= 1'b0;
      a_req_q   <= 24'd0;
      b_req_q   <= 24'd0;
      a_din_q   <= 8'd0;
      b_din_q   <= 8'd0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      m_start_q <= 1'b0;
      m_req_q   <= 24'd0;
      timeout_q <= 1'b0;
    end else begin
      m_start_q <= 1'b0;
      timeout_q <= abort_d;
      if (a_take_d) begin
        a_pend_q <= 1'b1;
        a_req_q  <= {a_read, a_addr, a_subaddr, a_dout};
      end
      if (b_take_d) begin
        b_pend_q <= 1'b1;
        b_req_q  <= {b_read, b_addr, b_subaddr, b_dout};
      end
      case (state_q)
        ST_IDLE: begin
          if (a_pend_q || b_pend_q) begin
            m_start_q <= 1'b1;
            state_q   <= ST_ISSUE;
            if (win_b_d) begin
              m_req_q  <= b_req_q;
              b_pend_q <= 1'b0;
              grant_q  <= GR_B;
            end else begin
              m_req_q  <= a_req_q;
              a_pend_q <= 1'b0;
              grant_q  <= GR_A;
            end
          end
        end
        ST_ISSUE: begin
          if (!m_end) begin
            state_q <= ST_BUSY;
          end
        end
        default: ;
      endcase
      // Completion and watchdog abort share the same hand-back path.
      if (done_d || abort_d) begin
        if (grant_q == GR_B) begin
          b_din_q <= cap_din_d;
          b_ack_q <= cap_ack_d;
        end else if (grant_q == GR_A) begin
          a_din_q <= cap_din_d;
          a_ack_q <= cap_ack_d;
        end
        last_b_q <= (grant_q == GR_B);
        grant_q  <= GR_NONE;
        state_q  <= ST_IDLE;
      end
    end
  end

  assign a_din   = a_din_q;
  assign a_ack   = a_ack_q;
  assign a_end   = ~(a_pend_q | (grant_q == GR_A));
  assign b_din   = b_din_q;
  assign b_ack   = b_ack_q;
  assign b_end   = ~(b_pend_q | (grant_q == GR_B));
  assign m_start = m_start_q;
  assign {m_read, m_addr, m_subaddr, m_dout} = m_req_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb/tb_i2c_arbiter.sv - randomized self-checking bench for i2c_arbiter
module tb_i2c_arbiter;
  logic       clk_sys = 1'b0;
  logic       reset = 1'b0;
  logic       a_start = 1'b0, a_read = 1'b0;
  logic [6:0] a_addr = 7'd0;
  logic [7:0] a_subaddr = 8'd0, a_dout = 8'd0;
  logic [7:0] a_din;
  logic       a_ack, a_end;
  logic       b_start = 1'b0, b_read = 1'b0;
  logic [6:0] b_addr = 7'd0;
  logic [7:0] b_subaddr = 8'd0, b_dout = 8'd0;
  logic [7:0] b_din;
  logic       b_ack, b_end;
  logic       m_start, m_read;
  logic [6:0] m_addr;
  logic [7:0] m_subaddr, m_dout;
  logic [7:0] m_din = 8'd0;
  logic       m_ack = 1'b0;
  logic       m_end = 1'b1;
  logic       timeout;

  i2c_arbiter #(.TMO_CYCLES(24'd100)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .a_start(a_start), .a_read(a_read), .a_addr(a_addr), .a_subaddr(a_subaddr),
    .a_dout(a_dout), .a_din(a_din), .a_ack(a_ack), .a_end(a_end),
    .b_start(b_start), .b_read(b_read), .b_addr(b_addr), .b_subaddr(b_subaddr),
    .b_dout(b_dout), .b_din(b_din), .b_ack(b_ack), .b_end(b_end),
    .m_start(m_start), .m_read(m_read), .m_addr(m_addr), .m_subaddr(m_subaddr),
    .m_dout(m_dout), .m_din(m_din), .m_ack(m_ack), .m_end(m_end),
    .timeout(timeout)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int mstart_hi = 0;
  int to_hi = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;
  always @(posedge clk_sys) if (m_start) mstart_hi <= mstart_hi + 1;
  always @(posedge clk_sys) if (timeout) to_hi <= to_hi + 1;

  localparam logic [45:0] RST_OUT = {1'b0, 1'b0, 7'h00, 8'h00, 8'h00,
                                     8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
  wire [45:0] outs = {m_start, m_read, m_addr, m_subaddr, m_dout,
                      a_din, a_ack, a_end, b_din, b_ack, b_end, timeout};

  // Expected per-port results and round-robin history.
  logic [7:0] exp_a_din = 8'd0, exp_b_din = 8'd0;
  logic       exp_a_ack = 1'b0, exp_b_ack = 1'b0;
  bit         exp_last_b = 1'b1;

  logic [23:0] log_req[$];
  int          log_cyc[$];
  logic [7:0]  rsp_din[$];
  bit          rsp_ack[$];
  int          rsp_lat[$];
  bit          mdl_hang = 1'b0;

  // Master model: drops m_end 2 cycles after m_start, returns the queued response.
  initial begin : master_model
    logic [7:0] d;
    logic       k;
    int         lat;
    forever begin
      @(posedge clk_sys); #1;
      if (m_start) begin
        log_req.push_back({m_read, m_addr, m_subaddr, m_dout});
        log_cyc.push_back(cyc);
        d   = (rsp_din.size() > 0) ? rsp_din.pop_front() : 8'h00;
        k   = (rsp_ack.size() > 0) ? rsp_ack.pop_front() : 1'b1;
        lat = (rsp_lat.size() > 0) ? rsp_lat.pop_front() : 5;
        repeat (2) @(posedge clk_sys);
        #1;
        m_end = 1'b0;
        m_din = 8'($urandom);
        m_ack = 1'($urandom);
        if (mdl_hang) begin
          while (mdl_hang) begin @(posedge clk_sys); #1; end
        end else begin
          repeat (lat) @(posedge clk_sys);
          #1;
        end
        m_din = d;
        m_ack = k;
        m_end = 1'b1;
      end
    end
  end

  task automatic push_rsp(input logic [7:0] d, input bit k, input int lat);
    rsp_din.push_back(d);
    rsp_ack.push_back(k);
    rsp_lat.push_back(lat);
  endtask

  task automatic fire(input bit do_a, input bit do_b, input logic [23:0] ra, input logic [23:0] rb);
    if (do_a) {a_read, a_addr, a_subaddr, a_dout} = ra;
    if (do_b) {b_read, b_addr, b_subaddr, b_dout} = rb;
    a_start = do_a;
    b_start = do_b;
    @(posedge clk_sys); #1;
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int t = 0;
    while (!(a_end && b_end && m_end) && t < budget) begin
      @(posedge clk_sys); #1;
      t++;
    end
    ok = a_end && b_end && m_end;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk_sys); #1;
    reset = 1'b0;
    exp_a_din = 8'd0; exp_b_din = 8'd0;
    exp_a_ack = 1'b0; exp_b_ack = 1'b0;
    exp_last_b = 1'b1;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (outs !== RST_OUT) begin n_bad++; $display("FAIL reset_async: got %h want %h", outs, RST_OUT); end
    @(posedge clk_sys); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    n_cmp++;
    if (outs !== RST_OUT) begin n_bad++; $display("FAIL reset_idle: got %h want %h", outs, RST_OUT); end
  endtask

  task automatic test_single_write_a();
    int n0, s0, t;
    n0 = log_req.size();
    s0 = mstart_hi;
    push_rsp(8'h00, 1'b1, 50);
    fire(1'b1, 1'b0, {1'b0, 7'h39, 8'h08, 8'h35}, 24'd0);
    n_cmp++;
    if ({a_end, m_start} !== 2'b00) begin n_bad++; $display("FAIL write_a_pending: got end,start=%b want 00", {a_end, m_start}); end
    @(posedge clk_sys); #1;
    n_cmp++;
    if ({m_start, m_read, m_addr, m_subaddr, m_dout} !== {1'b1, 1'b0, 7'h39, 8'h08, 8'h35}) begin
      n_bad++; $display("FAIL write_a_issue: got %b %b %h %h %h", m_start, m_read, m_addr, m_subaddr, m_dout);
    end
    t = 0;
    while (!a_end && t < 300) begin @(posedge clk_sys); #1; t++; end
    n_cmp++;
    if (a_end !== 1'b1) begin n_bad++; $display("FAIL write_a_done: got a_end %b want 1 within 300 cycles", a_end); end
    n_cmp++;
    if ((log_cyc.size() > n0 ? cyc - log_cyc[n0] : -1) !== 53) begin
      n_bad++; $display("FAIL write_a_latency: got %0d want 53", log_cyc.size() > n0 ? cyc - log_cyc[n0] : -1);
    end
    n_cmp++;
    if ({a_din, a_ack} !== {8'h00, 1'b1}) begin n_bad++; $display("FAIL write_a_result: got %h/%b want 00/1", a_din, a_ack); end
    n_cmp++;
    if ({b_din, b_ack, b_end} !== {8'h00, 1'b0, 1'b1}) begin n_bad++; $display("FAIL write_a_b_untouched: got %h/%b/%b", b_din, b_ack, b_end); end
    repeat (5) @(posedge clk_sys);
    #1;
    n_cmp++;
    if (mstart_hi - s0 !== 1 || log_req.size() !== n0 + 1) begin
      n_bad++; $display("FAIL write_a_one_start: got %0d high cycles, %0d txns want 1", mstart_hi - s0, log_req.size() - n0);
    end
    exp_a_din = 8'h00; exp_a_ack = 1'b1; exp_last_b = 1'b0;
  endtask

  task automatic test_single_read_b();
    int n0;
    bit ok;
    logic [23:0] rb;
    n0 = log_req.size();
    rb = {1'b1, 7'h50, 8'h10, 8'h00};
    push_rsp(8'hA5, 1'b1, $urandom_range(3, 20));
    fire(1'b0, 1'b1, 24'd0, rb);
    wait_idle(200, ok);
    n_cmp++;
    if (!ok || log_req.size() !== n0 + 1 || log_req[n0] !== rb) begin
      n_bad++; $display("FAIL read_b_txn: got ok=%b txns=%0d want 1 with %h", ok, log_req.size() - n0, rb);
    end
    n_cmp++;
    if ({b_din, b_ack} !== {8'hA5, 1'b1}) begin n_bad++; $display("FAIL read_b_result: got %h/%b want a5/1", b_din, b_ack); end
    n_cmp++;
    if ({a_din, a_ack} !== {exp_a_din, exp_a_ack}) begin n_bad++; $display("FAIL read_b_a_untouched: got %h/%b want %h/%b", a_din, a_ack, exp_a_din, exp_a_ack); end
    exp_b_din = 8'hA5; exp_b_ack = 1'b1; exp_last_b = 1'b1;
  endtask

  task automatic test_tie();
    int n0, la;
    bit ok;
    logic [23:0] ra, rb;
    do_reset();
    n0 = log_req.size();
    ra = 24'($urandom);
    rb = 24'($urandom);
    la = $urandom_range(3, 20);
    push_rsp(8'h11, 1'b1, la);
    push_rsp(8'h22, 1'b0, $urandom_range(3, 20));
    fire(1'b1, 1'b1, ra, rb);
    wait_idle(400, ok);
    n_cmp++;
    if (!ok || log_req.size() !== n0 + 2 || log_req[n0] !== ra || log_req[n0+1] !== rb) begin
      n_bad++; $display("FAIL tie_a_first: got ok=%b txns=%0d want A(%h) then B(%h)", ok, log_req.size() - n0, ra, rb);
    end
    n_cmp++;
    if ((log_cyc.size() > n0 + 1 ? log_cyc[n0+1] - log_cyc[n0] : -1) !== la + 4) begin
      n_bad++; $display("FAIL tie_gap: got %0d want %0d", log_cyc.size() > n0 + 1 ? log_cyc[n0+1] - log_cyc[n0] : -1, la + 4);
    end
    n_cmp++;
    if ({a_din, a_ack, b_din, b_ack} !== {8'h11, 1'b1, 8'h22, 1'b0}) begin
      n_bad++; $display("FAIL tie_results: got %h/%b %h/%b want 11/1 22/0", a_din, a_ack, b_din, b_ack);
    end
    // A alone, then a tie: B was not served last, so B wins.
    push_rsp(8'h33, 1'b1, 4);
    fire(1'b1, 1'b0, ra, 24'd0);
    wait_idle(200, ok);
    n0 = log_req.size();
    ra = 24'($urandom);
    rb = 24'($urandom);
    push_rsp(8'h44, 1'b1, $urandom_range(3, 20));
    push_rsp(8'h55, 1'b1, $urandom_range(3, 20));
    fire(1'b1, 1'b1, ra, rb);
    wait_idle(400, ok);
    n_cmp++;
    if (!ok || log_req.size() !== n0 + 2 || log_req[n0] !== rb || log_req[n0+1] !== ra) begin
      n_bad++; $display("FAIL tie_b_first: got ok=%b txns=%0d want B(%h) then A(%h)", ok, log_req.size() - n0, rb, ra);
    end
    n_cmp++;
    if ({a_din, b_din} !== {8'h55, 8'h44}) begin n_bad++; $display("FAIL tie_b_results: got %h %h want 55 44", a_din, b_din); end
    exp_a_din = 8'h55; exp_a_ack = 1'b1; exp_b_din = 8'h44; exp_b_ack = 1'b1; exp_last_b = 1'b0;
  endtask

  task automatic test_ignore_busy();
    int n0, s0, t;
    bit ok;
    logic [23:0] ra;
    n0 = log_req.size();
    s0 = mstart_hi;
    ra = 24'($urandom);
    push_rsp(8'h66, 1'b1, 30);
    fire(1'b1, 1'b0, ra, 24'd0);
    t = 0;
    while (m_end && t < 20) begin @(posedge clk_sys); #1; t++; end
    repeat (3) @(posedge clk_sys);
    #1;
    fire(1'b1, 1'b0, ~ra, 24'd0);
    wait_idle(200, ok);
    repeat (10) @(posedge clk_sys);
    #1;
    n_cmp++;
    if (!ok || log_req.size() !== n0 + 1 || mstart_hi - s0 !== 1 || log_req[n0] !== ra) begin
      n_bad++; $display("FAIL ignore_busy: got ok=%b txns=%0d pulses=%0d want 1 txn of %h", ok, log_req.size() - n0, mstart_hi - s0, ra);
    end
    n_cmp++;
    if ({a_din, a_ack} !== {8'h66, 1'b1}) begin n_bad++; $display("FAIL ignore_busy_result: got %h/%b want 66/1", a_din, a_ack); end
    exp_a_din = 8'h66; exp_a_ack = 1'b1; exp_last_b = 1'b0;
  endtask

  task automatic test_nack();
    int n0;
    bit ok;
    logic [7:0] d;
    logic [23:0] ra;
    d = 8'($urandom);
    push_rsp(d, 1'b0, $urandom_range(3, 20));
    fire(1'b0, 1'b1, 24'd0, 24'($urandom));
    wait_idle(200, ok);
    n_cmp++;
    if (!ok || {b_din, b_ack, b_end} !== {d, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL nack_b: got ok=%b %h/%b/%b want %h/0/1", ok, b_din, b_ack, b_end, d);
    end
    n0 = log_req.size();
    ra = 24'($urandom);
    push_rsp(8'h77, 1'b1, 6);
    fire(1'b1, 1'b0, ra, 24'd0);
    wait_idle(200, ok);
    n_cmp++;
    if (!ok || log_req.size() !== n0 + 1 || {a_din, a_ack} !== {8'h77, 1'b1}) begin
      n_bad++; $display("FAIL nack_recover: got ok=%b txns=%0d %h/%b want 1 77/1", ok, log_req.size() - n0, a_din, a_ack);
    end
    exp_b_din = d; exp_b_ack = 1'b0; exp_a_din = 8'h77; exp_a_ack = 1'b1; exp_last_b = 1'b0;
  endtask

  task automatic test_random();
    int n0, mode, t, errs;
    bit ok, x;
    bit ord[$];
    logic [23:0] exp_req[$];
    logic [23:0] ra, rb;
    logic [7:0] d;
    bit k;
    do_reset();
    for (int it = 0; it < 24; it++) begin
      n0 = log_req.size();
      mode = $urandom_range(0, 3);
      ra = 24'($urandom);
      rb = 24'($urandom);
      x = 1'($urandom);
      ord.delete();
      exp_req.delete();
      case (mode)
        0: ord.push_back(1'b0);
        1: ord.push_back(1'b1);
        2: begin ord.push_back(~exp_last_b); ord.push_back(exp_last_b); end
        default: begin ord.push_back(x); ord.push_back(~x); end
      endcase
      for (int i = 0; i < ord.size(); i++) begin
        d = 8'($urandom);
        k = 1'($urandom);
        push_rsp(d, k, $urandom_range(3, 30));
        if (ord[i]) begin exp_b_din = d; exp_b_ack = k; exp_req.push_back(rb); end
        else begin exp_a_din = d; exp_a_ack = k; exp_req.push_back(ra); end
        exp_last_b = ord[i];
      end
      case (mode)
        0: fire(1'b1, 1'b0, ra, 24'd0);
        1: fire(1'b0, 1'b1, 24'd0, rb);
        2: fire(1'b1, 1'b1, ra, rb);
        default: begin
          fire(!x, x, ra, rb);
          t = 0;
          while (m_end && t < 20) begin @(posedge clk_sys); #1; t++; end
          if (x) fire(1'b1, 1'b1, ra, ~rb);
          else fire(1'b1, 1'b1, ~ra, rb);
        end
      endcase
      wait_idle(600, ok);
      errs = 0;
      for (int i = 0; i < exp_req.size(); i++)
        if (log_req.size() <= n0 + i || log_req[n0+i] !== exp_req[i]) errs++;
      n_cmp++;
      if (!ok || errs != 0 || log_req.size() !== n0 + exp_req.size()) begin
        n_bad++; $display("FAIL rand_order[%0d] mode %0d: got ok=%b txns=%0d bad=%0d want %0d", it, mode, ok, log_req.size() - n0, errs, exp_req.size());
      end
      n_cmp++;
      if ({a_din, a_ack, b_din, b_ack} !== {exp_a_din, exp_a_ack, exp_b_din, exp_b_ack}) begin
        n_bad++; $display("FAIL rand_result[%0d]: got %h/%b %h/%b want %h/%b %h/%b", it, a_din, a_ack, b_din, b_ack, exp_a_din, exp_a_ack, exp_b_din, exp_b_ack);
      end
    end
  endtask

`ifdef I2C_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n0, t;
    n0 = log_req.size();
    mdl_hang = 1'b1;
    fire(1'b1, 1'b0, 24'($urandom), 24'd0);
    t = 0;
    while (!timeout && t < 400) begin @(posedge clk_sys); #1; t++; end
    n_cmp++;
    if (timeout !== 1'b1 || (log_cyc.size() > n0 ? cyc - log_cyc[n0] : -1) !== 100) begin
      n_bad++; $display("FAIL timeout_pulse: got %b after %0d cycles want 1 after 100", timeout, log_cyc.size() > n0 ? cyc - log_cyc[n0] : -1);
    end
    n_cmp++;
    if ({a_din, a_ack, a_end} !== {8'hFF, 1'b0, 1'b1}) begin n_bad++; $display("FAIL timeout_result: got %h/%b/%b want ff/0/1", a_din, a_ack, a_end); end
    @(posedge clk_sys); #1;
    n_cmp++;
    if (timeout !== 1'b0) begin n_bad++; $display("FAIL timeout_width: got %b want 0", timeout); end
    mdl_hang = 1'b0;
    t = 0;
    while (!m_end && t < 20) begin @(posedge clk_sys); #1; t++; end
    exp_a_din = 8'hFF; exp_a_ack = 1'b0; exp_last_b = 1'b0;
  endtask
`else
  task automatic test_no_timeout();
    n_cmp++;
    if (to_hi !== 0) begin n_bad++; $display("FAIL timeout_tied: got %0d pulses want 0", to_hi); end
  endtask
`endif

  task automatic test_reset_mid();
    int n0, t;
    mdl_hang = 1'b1;
    fire(1'b1, 1'b0, 24'($urandom), 24'd0);
    t = 0;
    while (m_end && t < 20) begin @(posedge clk_sys); #1; t++; end
    repeat (5) @(posedge clk_sys);
    #1;
    fire(1'b0, 1'b1, 24'd0, 24'($urandom));
    #3 reset = 1'b1;
    #1;
    n_cmp++;
    if (outs !== RST_OUT) begin n_bad++; $display("FAIL reset_mid: got %h want %h", outs, RST_OUT); end
    @(posedge clk_sys); #1;
    reset = 1'b0;
    n0 = log_req.size();
    repeat (10) @(posedge clk_sys);
    #1;
    n_cmp++;
    if (log_req.size() !== n0 || {a_end, b_end} !== 2'b11) begin
      n_bad++; $display("FAIL reset_mid_dropped: got %0d new txns ends=%b want 0 11", log_req.size() - n0, {a_end, b_end});
    end
    mdl_hang = 1'b0;
    t = 0;
    while (!m_end && t < 20) begin @(posedge clk_sys); #1; t++; end
  endtask

  initial begin
    test_reset();
    test_single_write_a();
    test_single_read_b();
    test_tie();
    test_ignore_busy();
    test_nack();
    test_random();
`ifdef I2C_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
